pipe_hazard_ctrl: RTL and testbench

Hazard and sequencing controller for the five-stage pipeline. It sits beside the ID/EX, EX/MEM and MEM/WB pipeline registers. It generates the forwarding selects for the ID-stage operand muxes and the load-use stall/bubble controls. A small FSM freezes the pipeline while a memory-stage I/O access waits for a slow device, with a timeout.

---
 rtl/pipe_pkg.sv | 38 +++
 rtl/pipe_fwd_unit.sv | 31 +++
 rtl/pipe_hazard_ctrl.sv | 139 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared encodings and forwarding helper for the pipeline hazard controller
package pipe_pkg;

    // ID-stage operand mux selects
    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXE   = 2'b01;
    localparam logic [1:0] FWD_MEM   = 2'b10;
    localparam logic [1:0] FWD_MDATA = 2'b11;

    // I/O freeze sequencer states
    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_WAIT = 2'b01,
        ST_REL  = 2'b10
    } state_t;

    // Select the freshest producer of one source register; EX beats MEM, r0 is never forwarded.
    // An EX-stage load has no data yet, so it falls through to the load-use stall instead.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] ern,
        input logic       ewreg,
        input logic       em2reg,
        input logic [4:0] mrn,
        input logic       mwreg,
        input logic       mm2reg
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (ewreg && (ern != 5'd0) && (ern == src) && !em2reg) begin
            sel = FWD_EXE;
        end else if (mwreg && (mrn != 5'd0) && (mrn == src)) begin
            sel = mm2reg ? FWD_MDATA : FWD_MEM;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipe_fwd_unit.sv
// rtl/pipe_fwd_unit.sv - combinational operand forwarding selects and load-use detect
module pipe_fwd_unit
    import pipe_pkg::*;
(
    input  logic [4:0] i_drs,
    input  logic [4:0] i_drt,
    input  logic       i_duse_rs,
    input  logic       i_duse_rt,
    input  logic [4:0] i_ern,
    input  logic       i_ewreg,
    input  logic       i_em2reg,
    input  logic [4:0] i_mrn,
    input  logic       i_mwreg,
    input  logic       i_mm2reg,
    output logic [1:0] o_fwda,
    output logic [1:0] o_fwdb,
    output logic       o_lu
);

    logic w_ex_load;

    // Forwarding selects and load-use hazard: an EX-stage load feeding a register the ID instruction reads
    always_comb begin
        o_fwda    = fwd_sel(i_drs, i_ern, i_ewreg, i_em2reg, i_mrn, i_mwreg, i_mm2reg);
        o_fwdb    = fwd_sel(i_drt, i_ern, i_ewreg, i_em2reg, i_mrn, i_mwreg, i_mm2reg);
        w_ex_load = i_ewreg && i_em2reg && (i_ern != 5'd0);
        o_lu      = w_ex_load && ((i_duse_rs && (i_ern == i_drs)) ||
                                  (i_duse_rt && (i_ern == i_drt)));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - forwarding, load-use stall and I/O wait sequencer for the five-stage pipeline
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CW      = 8
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [4:0] drs,
    input  logic [4:0] drt,
    input  logic       duse_rs,
    input  logic       duse_rt,
    input  logic [4:0] ern,
    input  logic       ewreg,
    input  logic       em2reg,
    input  logic [4:0] mrn,
    input  logic       mwreg,
    input  logic       mm2reg,
    input  logic       mio_req,
    input  logic       io_ready,
    output logic [1:0] fwda,
    output logic [1:0] fwdb,
    output logic       wpcir,
    output logic       dbubble,
    output logic       pipe_en,
    output logic       wb_bubble,
    output logic       io_req,
    output logic       io_lat,
    output logic       io_timeout
);

    // Count value seen in the last permitted WAIT cycle
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic            r_timeout;
    logic            w_lu;
    logic            w_tmo_hit;
    logic [1:0]      w_fwda;
    logic [1:0]      w_fwdb;

    pipe_fwd_unit u_fwd (
        .i_drs     (drs),
        .i_drt     (drt),
        .i_duse_rs (duse_rs),
        .i_duse_rt (duse_rt),
        .i_ern     (ern),
        .i_ewreg   (ewreg),
        .i_em2reg  (em2reg),
        .i_mrn     (mrn),
        .i_mwreg   (mwreg),
        .i_mm2reg  (mm2reg),
        .o_fwda    (w_fwda),
        .o_fwdb    (w_fwdb),
        .o_lu      (w_lu)
    );

    assign fwda       = w_fwda;
    assign fwdb       = w_fwdb;
    assign io_timeout = r_timeout;

    // Timeout only when the device has not answered; a ready in the final cycle is a success
    assign w_tmo_hit = (r_state == ST_WAIT) && !io_ready && (r_cnt == TMO_LAST);

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Wait-cycle counter: cleared outside WAIT, saturating inside it
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (r_state == ST_WAIT) begin
            if (r_cnt != {CW{1'b1}}) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end else begin
            r_cnt <= '0;
        end
    end

    // Sticky abort flag, cleared only by reset
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_timeout <= 1'b0;
        end else if (w_tmo_hit) begin
            r_timeout <= 1'b1;
        end
    end

    // Next state and pipeline controls; the freeze is combinational so it bites in the request cycle
    always_comb begin
        w_state_nxt = r_state;
        pipe_en     = 1'b1;
        wb_bubble   = 1'b0;
        io_req      = 1'b0;
        io_lat      = 1'b0;
        wpcir       = !w_lu;
        dbubble     = w_lu;
        case (r_state)
            ST_RUN: begin
                if (mio_req) begin
                    pipe_en     = 1'b0;
                    wpcir       = 1'b0;
                    dbubble     = 1'b0;
                    wb_bubble   = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                io_req    = 1'b1;
                pipe_en   = 1'b0;
                wpcir     = 1'b0;
                dbubble   = 1'b0;
                wb_bubble = 1'b1;
                if (io_ready || w_tmo_hit) begin
                    w_state_nxt = ST_REL;
                end
            end
            ST_REL: begin
                // The finishing I/O instruction is still in MEM, so mio_req is not a new request here
                io_lat      = 1'b1;
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    logic       clock = 1'b0;
    logic       resetn;
    logic [4:0] drs, drt, ern, mrn;
    logic       duse_rs, duse_rt, ewreg, em2reg, mwreg, mm2reg, mio_req, io_ready;
    logic [1:0] fwda, fwdb;
    logic       wpcir, dbubble, pipe_en, wb_bubble, io_req, io_lat, io_timeout;

    typedef struct packed {
        logic [1:0] fwda;
        logic [1:0] fwdb;
        logic       wpcir;
        logic       dbubble;
        logic       pipe_en;
        logic       wb_bubble;
        logic       io_req;
        logic       io_lat;
        logic       io_timeout;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    pipe_hazard_ctrl #(.TIMEOUT(4), .CW(8)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .drs        (drs),
        .drt        (drt),
        .duse_rs    (duse_rs),
        .duse_rt    (duse_rt),
        .ern        (ern),
        .ewreg      (ewreg),
        .em2reg     (em2reg),
        .mrn        (mrn),
        .mwreg      (mwreg),
        .mm2reg     (mm2reg),
        .mio_req    (mio_req),
        .io_ready   (io_ready),
        .fwda       (fwda),
        .fwdb       (fwdb),
        .wpcir      (wpcir),
        .dbubble    (dbubble),
        .pipe_en    (pipe_en),
        .wb_bubble  (wb_bubble),
        .io_req     (io_req),
        .io_lat     (io_lat),
        .io_timeout (io_timeout)
    );

    // Order: fwda, fwdb, wpcir, dbubble, pipe_en, wb_bubble, io_req, io_lat, io_timeout
    task automatic push(input logic [1:0] fa, input logic [1:0] fb, input logic wp, input logic db,
                        input logic pe, input logic wbb, input logic rq, input logic lat,
                        input logic tmo);
        exp_t e;
        e.fwda = fa; e.fwdb = fb; e.wpcir = wp; e.dbubble = db; e.pipe_en = pe;
        e.wb_bubble = wbb; e.io_req = rq; e.io_lat = lat; e.io_timeout = tmo;
        exp_q.push_back(e);
    endtask

    task automatic cmp(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string step);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s.queue: observed 0 entries expected 1", step);
            return;
        end
        e = exp_q.pop_front();
        cmp({step, ".fwda"},       fwda,       e.fwda);
        cmp({step, ".fwdb"},       fwdb,       e.fwdb);
        cmp({step, ".wpcir"},      {1'b0, wpcir},      {1'b0, e.wpcir});
        cmp({step, ".dbubble"},    {1'b0, dbubble},    {1'b0, e.dbubble});
        cmp({step, ".pipe_en"},    {1'b0, pipe_en},    {1'b0, e.pipe_en});
        cmp({step, ".wb_bubble"},  {1'b0, wb_bubble},  {1'b0, e.wb_bubble});
        cmp({step, ".io_req"},     {1'b0, io_req},     {1'b0, e.io_req});
        cmp({step, ".io_lat"},     {1'b0, io_lat},     {1'b0, e.io_lat});
        cmp({step, ".io_timeout"}, {1'b0, io_timeout}, {1'b0, e.io_timeout});
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic sample(input string step);
        @(negedge clock);
        pop_check(step);
    endtask

    task automatic clear_in();
        drs = 5'd0; drt = 5'd0; duse_rs = 1'b0; duse_rt = 1'b0;
        ern = 5'd0; ewreg = 1'b0; em2reg = 1'b0;
        mrn = 5'd0; mwreg = 1'b0; mm2reg = 1'b0;
        mio_req = 1'b0; io_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn = 1'b0;
        clear_in();
        #2;
        push(2'b00, 2'b00, 1, 0, 1, 0, 0, 0, 0); pop_check("reset");
        tick(); resetn = 1'b1;

        // Forwarding
        tick(); clear_in(); ern = 5'd5; ewreg = 1; drs = 5'd5; duse_rs = 1;
        push(2'b01, 2'b00, 1, 0, 1, 0, 0, 0, 0); sample("ex_alu");
        tick(); clear_in(); ern = 5'd7; mrn = 5'd7; ewreg = 1; mwreg = 1; drt = 5'd7; duse_rt = 1;
        push(2'b00, 2'b01, 1, 0, 1, 0, 0, 0, 0); sample("dbl_ex");
        tick(); ern = 5'd0;
        push(2'b00, 2'b10, 1, 0, 1, 0, 0, 0, 0); sample("dbl_mem");
        tick(); mm2reg = 1;
        push(2'b00, 2'b11, 1, 0, 1, 0, 0, 0, 0); sample("dbl_mdata");
        tick(); clear_in(); mrn = 5'd9; mwreg = 1; mm2reg = 1; drs = 5'd9; duse_rs = 1;
        push(2'b11, 2'b00, 1, 0, 1, 0, 0, 0, 0); sample("fwda_mdata");
        tick(); clear_in(); ewreg = 1; em2reg = 1; mwreg = 1; duse_rs = 1; duse_rt = 1;
        push(2'b00, 2'b00, 1, 0, 1, 0, 0, 0, 0); sample("r0_none");

        // Load-use
        tick(); clear_in(); ewreg = 1; em2reg = 1; ern = 5'd3; drt = 5'd3; duse_rt = 1;
        push(2'b00, 2'b00, 0, 1, 1, 0, 0, 0, 0); sample("lu_stall");
        tick(); ewreg = 0; em2reg = 0; ern = 5'd0; mrn = 5'd3; mwreg = 1; mm2reg = 1;
        push(2'b00, 2'b11, 1, 0, 1, 0, 0, 0, 0); sample("lu_after");
        tick(); clear_in(); ewreg = 1; em2reg = 1; ern = 5'd3; drt = 5'd3; duse_rt = 0;
        push(2'b00, 2'b00, 1, 0, 1, 0, 0, 0, 0); sample("lu_unused");

        // I/O access, device ready in the third WAIT cycle
        tick(); clear_in(); mio_req = 1;
        push(2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 0); sample("io_reqcyc");
        for (int i = 0; i < 3; i++) begin
            tick(); io_ready = (i == 2);
            push(2'b00, 2'b00, 0, 0, 0, 1, 1, 0, 0); sample($sformatf("io_wait%0d", i));
        end
        tick(); io_ready = 0;
        push(2'b00, 2'b00, 1, 0, 1, 0, 0, 1, 0); sample("io_rel");
        tick(); mio_req = 0;
        push(2'b00, 2'b00, 1, 0, 1, 0, 0, 0, 0); sample("io_run");

        // Ready coincides with the last allowed WAIT cycle: success, no timeout
        tick(); mio_req = 1;
        push(2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 0); sample("edge_req");
        for (int i = 0; i < 4; i++) begin
            tick(); io_ready = (i == 3);
            push(2'b00, 2'b00, 0, 0, 0, 1, 1, 0, 0); sample($sformatf("edge_wait%0d", i));
        end
        tick(); io_ready = 0; mio_req = 0;
        push(2'b00, 2'b00, 1, 0, 1, 0, 0, 1, 0); sample("edge_rel");
        tick();
        push(2'b00, 2'b00, 1, 0, 1, 0, 0, 0, 0); sample("edge_run");

        // Timeout: exactly four WAIT cycles, then sticky flag
        tick(); mio_req = 1;
        push(2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 0); sample("tmo_req");
        for (int i = 0; i < 4; i++) begin
            tick();
            push(2'b00, 2'b00, 0, 0, 0, 1, 1, 0, 0); sample($sformatf("tmo_wait%0d", i));
        end
        tick(); mio_req = 0;
        push(2'b00, 2'b00, 1, 0, 1, 0, 0, 1, 1); sample("tmo_rel");
        tick();
        push(2'b00, 2'b00, 1, 0, 1, 0, 0, 0, 1); sample("tmo_run");
        tick();
        push(2'b00, 2'b00, 1, 0, 1, 0, 0, 0, 1); sample("tmo_sticky");

        // Asynchronous reset in the middle of WAIT
        tick(); mio_req = 1;
        push(2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 1); sample("rst_req");
        tick();
        push(2'b00, 2'b00, 0, 0, 0, 1, 1, 0, 1); sample("rst_wait");
        #2; mio_req = 0; resetn = 1'b0;
        #1;
        push(2'b00, 2'b00, 1, 0, 1, 0, 0, 0, 0); pop_check("rst_async");
        tick(); resetn = 1'b1;
        tick();
        push(2'b00, 2'b00, 1, 0, 1, 0, 0, 0, 0); sample("rst_after");

        // I/O request together with a load-use hazard, and load-use honoured in REL
        tick(); clear_in(); ewreg = 1; em2reg = 1; ern = 5'd3; drs = 5'd3; duse_rs = 1; mio_req = 1;
        push(2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 0); sample("iolu_req");
        tick(); io_ready = 1;
        push(2'b00, 2'b00, 0, 0, 0, 1, 1, 0, 0); sample("iolu_wait");
        tick(); io_ready = 0;
        push(2'b00, 2'b00, 0, 1, 1, 0, 0, 1, 0); sample("iolu_rel");
        tick(); clear_in();
        push(2'b00, 2'b00, 1, 0, 1, 0, 0, 0, 0); sample("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
